// File: rtl/clk_gate_ctrl.sv
// Activity-driven enable generator for a clk_gate cell: gates after an idle window, restores via a timed wake.
// Optional build macro CLK_GATE_CTRL_STATS_EN adds a saturating count of cycles spent gated.
module clk_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic        free_clk,
   input  logic        reset_n,
   input  logic        busy,
   input  logic        wake_req,
   input  logic        test_override,
   output logic        func_en,
   output logic        pwr_en,
   output logic        gating_override,
   output logic        wake_ack,
   output logic        gated,
   output logic [31:0] gated_cycles
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      GATED = 2'd2,
      WAKE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_wake_ack;
   logic               w_wake_ack_nxt;
   logic               r_override;
   logic               w_act;

   assign w_act = busy | wake_req | test_override;

   always_ff @(posedge free_clk) begin
      if (!reset_n) begin
         r_state    <= RUN;
         r_cnt      <= '0;
         r_wake_ack <= 1'b0;
         r_override <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_wake_ack <= w_wake_ack_nxt;
         r_override <= test_override;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_wake_ack_nxt = 1'b0;
      case (r_state)
         RUN: begin
            if (w_act) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == IDLE_LAST) begin
               w_state_nxt = DRAIN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DRAIN: begin
            w_cnt_nxt   = '0;
            w_state_nxt = w_act ? RUN : GATED;
         end
         GATED: begin
            w_cnt_nxt = '0;
            if (w_act) begin
               w_state_nxt = WAKE;
            end
         end
         WAKE: begin
            // Activity is deliberately ignored here so a started wake always finishes.
            if (r_cnt == WAKE_LAST) begin
               w_state_nxt    = RUN;
               w_cnt_nxt      = '0;
               w_wake_ack_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign func_en         = (r_state == RUN);
   assign pwr_en          = (r_state != GATED);
   assign gated           = (r_state == GATED);
   assign wake_ack        = r_wake_ack;
   assign gating_override = r_override;

`ifdef CLK_GATE_CTRL_STATS_EN
   logic [31:0] r_gated_cycles;

   always_ff @(posedge free_clk) begin
      if (!reset_n) begin
         r_gated_cycles <= '0;
      end else if ((r_state == GATED) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
         r_gated_cycles <= r_gated_cycles + 32'd1;
      end
   end

   assign gated_cycles = r_gated_cycles;
`else
   assign gated_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clk_gate_ctrl;

   logic        free_clk = 1'b0;
   logic        reset_n;
   logic        busy;
   logic        wake_req;
   logic        test_override;
   logic        func_en;
   logic        pwr_en;
   logic        gating_override;
   logic        wake_ack;
   logic        gated;
   logic [31:0] gated_cycles;

   int tests  = 0;
   int errors = 0;

`ifdef CLK_GATE_CTRL_STATS_EN
   localparam logic [31:0] EXP_STATS7 = 32'd7;
`else
   localparam logic [31:0] EXP_STATS7 = 32'd0;
`endif

   clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(8)) dut (
      .free_clk        (free_clk),
      .reset_n         (reset_n),
      .busy            (busy),
      .wake_req        (wake_req),
      .test_override   (test_override),
      .func_en         (func_en),
      .pwr_en          (pwr_en),
      .gating_override (gating_override),
      .wake_ack        (wake_ack),
      .gated           (gated),
      .gated_cycles    (gated_cycles)
   );

   always #5 free_clk = ~free_clk;

   typedef struct {
      logic rst_n;
      logic bsy;
      logic wake;
      logic ovr;
      logic f;
      logic p;
      logic g;
      logic wa;
      logic go;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic rst_n, input logic bsy, input logic wake, input logic ovr,
                               input logic f, input logic p, input logic g, input logic wa, input logic go);
      vec_t v;
      v.rst_n = rst_n; v.bsy = bsy; v.wake = wake; v.ovr = ovr;
      v.f = f; v.p = p; v.g = g; v.wa = wa; v.go = go;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge free_clk);
      #1;
   endtask

   initial begin
      int on_cnt;
      int n;
      reset_n = 1'b0; busy = 1'b1; wake_req = 1'b0; test_override = 1'b0;

      // Each row: inputs applied before an edge, outputs expected after it.
      vecs[0]  = mk(0,1,0,0, 1,1,0,0,0);
      vecs[1]  = mk(0,1,0,0, 1,1,0,0,0);
      vecs[2]  = mk(0,1,0,0, 1,1,0,0,0);
      vecs[3]  = mk(1,1,0,0, 1,1,0,0,0);
      vecs[4]  = mk(1,0,0,0, 1,1,0,0,0);
      vecs[5]  = mk(1,0,0,0, 1,1,0,0,0);
      vecs[6]  = mk(1,0,0,0, 1,1,0,0,0);
      vecs[7]  = mk(1,0,0,0, 0,1,0,0,0);
      vecs[8]  = mk(1,0,0,0, 0,0,1,0,0);
      vecs[9]  = mk(1,0,0,0, 0,0,1,0,0);
      vecs[10] = mk(1,0,0,0, 0,0,1,0,0);
      vecs[11] = mk(1,0,0,0, 0,0,1,0,0);
      vecs[12] = mk(1,0,0,0, 0,0,1,0,0);
      vecs[13] = mk(1,0,1,0, 0,1,0,0,0);
      vecs[14] = mk(1,0,0,0, 0,1,0,0,0);
      vecs[15] = mk(1,0,0,0, 1,1,0,1,0);
      vecs[16] = mk(1,1,0,1, 1,1,0,0,1);
      vecs[17] = mk(1,1,0,0, 1,1,0,0,0);

      for (int i = 0; i < 18; i++) begin
         reset_n       = vecs[i].rst_n;
         busy          = vecs[i].bsy;
         wake_req      = vecs[i].wake;
         test_override = vecs[i].ovr;
         tick();
         chk($sformatf("v%0d_func_en", i), {31'd0, func_en}, {31'd0, vecs[i].f});
         chk($sformatf("v%0d_pwr_en", i), {31'd0, pwr_en}, {31'd0, vecs[i].p});
         chk($sformatf("v%0d_gated", i), {31'd0, gated}, {31'd0, vecs[i].g});
         chk($sformatf("v%0d_wake_ack", i), {31'd0, wake_ack}, {31'd0, vecs[i].wa});
         chk($sformatf("v%0d_gating_override", i), {31'd0, gating_override}, {31'd0, vecs[i].go});
         if (!vecs[i].rst_n) chk($sformatf("v%0d_gated_cycles", i), gated_cycles, 32'd0);
      end

      // Idle window broken by activity on the edge that would have completed it.
      for (int e = 1; e <= 8; e++) begin
         busy = (e == 4);
         tick();
         chk($sformatf("intr_e%0d_func_en", e), {31'd0, func_en}, (e == 8) ? 32'd0 : 32'd1);
      end
      busy = 1'b0;
      tick();
      chk("intr_gated", {31'd0, gated}, 32'd1);

      // Override from GATED wakes normally, then pins RUN.
      test_override = 1'b1;
      tick();
      chk("ovr_pwr_en", {31'd0, pwr_en}, 32'd1);
      chk("ovr_func_en_wake", {31'd0, func_en}, 32'd0);
      chk("ovr_gating_override", {31'd0, gating_override}, 32'd1);
      tick();
      tick();
      chk("ovr_wake_ack", {31'd0, wake_ack}, 32'd1);
      on_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (func_en && !gated) on_cnt++;
      end
      chk("ovr_stay_run", on_cnt, 32'd20);
      test_override = 1'b0;
      tick();
      chk("ovr_release", {31'd0, gating_override}, 32'd0);

      // Statistics over a fresh gated period, then reset mid-WAKE.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n = 0;
      while (!gated && n < 20) begin
         tick();
         n++;
      end
      chk("stats_enter_gated", {31'd0, gated}, 32'd1);
      for (int c = 0; c < 7; c++) tick();
      chk("stats_gated_cycles", gated_cycles, EXP_STATS7);
      wake_req = 1'b1;
      tick();
      chk("rstw_in_wake", {30'd0, func_en, pwr_en}, 32'd1);
      wake_req = 1'b0;
      reset_n  = 1'b0;
      tick();
      chk("rstw_func_en", {31'd0, func_en}, 32'd1);
      chk("rstw_pwr_en", {31'd0, pwr_en}, 32'd1);
      chk("rstw_wake_ack", {31'd0, wake_ack}, 32'd0);
      chk("rstw_gated", {31'd0, gated}, 32'd0);
      chk("rstw_gating_override", {31'd0, gating_override}, 32'd0);
      chk("rstw_gated_cycles", gated_cycles, 32'd0);
      tick();
      chk("rstw_no_ack_after", {31'd0, wake_ack}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

- Activity-driven controller that generates the enables for the `clk_gate` cell: `func_en`, `pwr_en` and `gating_override`.
- Runs on the free-running clock and watches unit activity.
- After a programmable idle window it gates the unit's clock, and restores the clock through a wake handshake.
- Sits beside each `clk_gate` instance in the SandPiper default project; its outputs connect directly to that instance's enable inputs.

## Interface
Parameters:
- `IDLE_CYCLES`, 16: consecutive idle cycles required before gating; legal range 1..2^CNT_W-1.
- `WAKE_CYCLES`, 2: cycles `pwr_en` is high before `func_en` re-asserts; legal range 1..2^CNT_W-1.
- `CNT_W`, 8: width of the shared idle/wake counter.

Ports (one clock; reset is synchronous and active-low):
- `free_clk` input 1: free-running clock; all state updates on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `busy` input 1: unit has work in flight; a high cycle counts as activity.
- `wake_req` input 1: level request to run the unit; counts as activity.
- `test_override` input 1: test/debug force-clock-on request.
- `func_en` output 1: functional enable to `clk_gate`.
- `pwr_en` output 1: power enable to `clk_gate`.
- `gating_override` output 1: override to `clk_gate`.
- `wake_ack` output 1: one-cycle pulse when the unit is clocked again after a wake.
- `gated` output 1: high while in GATED.
- `gated_cycles` output 32: statistics counter (see Configuration).

## Operation
- States: RUN, DRAIN, GATED, WAKE. Reset state is RUN.
- Output decode, all outputs registered (a direct function of the state register, or flops):
  - RUN: `func_en`=1, `pwr_en`=1.
  - DRAIN: `func_en`=0, `pwr_en`=1.
  - GATED: `func_en`=0, `pwr_en`=0, `gated`=1.
  - WAKE: `func_en`=0, `pwr_en`=1.
- `act` = `busy` | `wake_req` | `test_override`.
- RUN: if `act`, counter clears to 0. Otherwise the counter increments; when it equals IDLE_CYCLES-1 and `act`=0, the next state is DRAIN and the counter clears.
- DRAIN: lasts exactly one cycle. If `act`, go to RUN; otherwise go to GATED.
- GATED: if `act`, go to WAKE with the counter at 0; otherwise stay in GATED.
- WAKE: the counter increments each cycle. When it equals WAKE_CYCLES-1, go to RUN and pulse `wake_ack` for exactly one cycle, coincident with the first RUN cycle. `act` is ignored during WAKE: a wake always completes.
- `gating_override` is `test_override` registered one cycle.
- While `test_override`=1, the FSM never leaves RUN. An assertion in GATED starts a normal WAKE.
- The counter never wraps: its compare points are below 2^CNT_W-1.

## Timing
- Reset values: state RUN, `func_en`=1, `pwr_en`=1, `gating_override`=0, `wake_ack`=0, `gated`=0, counter 0, `gated_cycles`=0.
- Gate latency: with the first idle sample at edge 0, DRAIN is entered at edge IDLE_CYCLES and `pwr_en` falls at edge IDLE_CYCLES+1.
- Wake latency: with `act` sampled in GATED at edge 0:
  - `pwr_en` rises at edge 1.
  - `func_en` and `wake_ack` rise at edge 1+WAKE_CYCLES.
  - `wake_ack` falls at the next edge.
- Activity on the same edge that would complete the idle count resets the count; no DRAIN is entered.
- `reset_n` low at any edge, including mid-WAKE or in GATED, returns all outputs to reset values on that edge.

## Configuration
- Macro: `CLK_GATE_CTRL_STATS_EN`.
- Defined: `gated_cycles` increments once per cycle spent in GATED and saturates at 0xFFFFFFFF; it is cleared only by reset.
- Undefined: no counter flops exist, and `gated_cycles` is tied to 0.
- FSM behaviour is identical in both builds.

## Test plan
All scenarios use IDLE_CYCLES=4, WAKE_CYCLES=2.
- Reset: hold `reset_n`=0 for 3 cycles with `busy`=1 -> `func_en`=1, `pwr_en`=1, `wake_ack`=0, `gated_cycles`=0.
- Idle entry: `busy`=0 from edge 0 -> DRAIN at edge 4 (`func_en`=0), `pwr_en`=0 and `gated`=1 at edge 5.
- Idle interrupted: `busy` pulses high at edge 3 -> no DRAIN; a fresh 4-cycle window starts and DRAIN is entered at edge 8.
- Wake: `wake_req`=1 at edge 10 while GATED -> `pwr_en`=1 at edge 11, `func_en`=1 and `wake_ack`=1 at edge 13, `wake_ack`=0 at edge 14.
- Override: `test_override`=1 while GATED -> WAKE completes; the FSM stays in RUN for 20 idle cycles and `gating_override`=1 one cycle after assertion.
- Stats, with the macro defined: remain GATED for 7 cycles -> `gated_cycles`=7. Assert `reset_n`=0 during WAKE -> all outputs return to reset values on that edge.
